// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a program counter through a combinational ROM and
// latches each word into an instruction register, with stall, branch redirect and halt.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           INSTR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   stall,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0]  ir_pc,
  output logic                   ir_valid,
  output logic [3:0]             opcode,
  output logic                   halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0]  irPc_q, irPc_d;
  logic                   irValid_q, irValid_d;
  logic                   isHalt;

  assign isHalt = (instruction[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  // Branch beats stall beats halt detection beats a plain fetch; the PC never
  // advances past a halt word, so address keeps pointing at it while halted.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    irPc_d    = irPc_q;
    irValid_d = irValid_q;
    unique case (state_q)
      IDLE: begin
        irValid_d = 1'b0;
        state_d   = RUN;
        if (branch_valid) pc_d = branch_target;
      end
      RUN: begin
        if (branch_valid) begin
          pc_d      = branch_target;
          irValid_d = 1'b0;
        end else if (!stall) begin
          ir_d      = instruction;
          irPc_d    = pc_q;
          irValid_d = 1'b1;
          if (isHalt) state_d = HALTED;
          else        pc_d    = pc_q + ADDR_WIDTH'(1);
        end
      end
      HALTED: begin
        irValid_d = 1'b0;
        if (branch_valid) begin
          pc_d    = branch_target;
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        irValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      irPc_q    <= '0;
      irValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      irPc_q    <= irPc_d;
      irValid_q <= irValid_d;
    end
  end

  assign address  = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = irPc_q;
  assign ir_valid = irValid_q;
  assign opcode   = ir_q[INSTR_WIDTH-1 -: 4];
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a ROM model drives instruction from
// address, and expected fetches are queued when driven and compared when latched.
module tb_instruction_fetch;

  typedef struct packed {
    logic [8:0] instr;
    logic [7:0] pc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic [8:0] instruction;
  logic       stall;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic [8:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic [3:0] opcode;
  logic       halted;

  logic [8:0] rom [256];
  exp_t       sbQ [$];
  int         checks   = 0;
  int         failures = 0;

  instruction_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .instruction  (instruction),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .opcode       (opcode),
    .halted       (halted)
  );

  always #5 clock = ~clock;
  assign instruction = rom[address];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushExp(input logic [7:0] a);
    sbQ.push_back({rom[a], a});
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL reset_address got=%h want=00", address); end
    checks++; if (ir !== 9'h000) begin failures++; $display("[TB] FAIL reset_ir got=%h want=000", ir); end
    checks++; if (ir_pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_ir_pc got=%h want=00", ir_pc); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ir_valid got=%b want=0", ir_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b want=0", halted); end
    reset = 1'b0;
    tick();
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_ir_valid got=%b want=0", ir_valid); end
    checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL idle_address got=%h want=00", address); end
    pushExp(8'h00);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL first_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL first_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_ir_valid got=%b want=1", ir_valid); end
  endtask

  task automatic test_sequential();
    exp_t e;
    pushExp(8'h01);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL seq_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL seq_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_ir_valid got=%b want=1", ir_valid); end
    checks++; if (opcode !== e.instr[8:5]) begin failures++; $display("[TB] FAIL seq_opcode got=%h want=%h", opcode, e.instr[8:5]); end
    checks++; if (address !== 8'h02) begin failures++; $display("[TB] FAIL seq_address got=%h want=02", address); end
  endtask

  task automatic test_stall();
    exp_t e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ir !== 9'h0D1) begin failures++; $display("[TB] FAIL stall_ir got=%h want=0d1", ir); end
      checks++; if (ir_pc !== 8'h01) begin failures++; $display("[TB] FAIL stall_ir_pc got=%h want=01", ir_pc); end
      checks++; if (address !== 8'h02) begin failures++; $display("[TB] FAIL stall_address got=%h want=02", address); end
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_ir_valid got=%b want=1", ir_valid); end
    end
    stall = 1'b0;
    pushExp(8'h02);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL unstall_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL unstall_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (address !== 8'h03) begin failures++; $display("[TB] FAIL unstall_address got=%h want=03", address); end
  endtask

  task automatic test_halt();
    exp_t e;
    pushExp(8'h03);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL halt_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL halt_ir_valid got=%b want=1", ir_valid); end
    checks++; if (address !== 8'h03) begin failures++; $display("[TB] FAIL halt_address got=%h want=03", address); end
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      tick();
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halted_flag cyc=%0d got=%b want=1", i, halted); end
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL halted_ir_valid cyc=%0d got=%b want=0", i, ir_valid); end
      checks++; if (address !== 8'h03) begin failures++; $display("[TB] FAIL halted_address cyc=%0d got=%h want=03", i, address); end
      checks++; if (ir_pc !== 8'h03) begin failures++; $display("[TB] FAIL halted_ir_pc cyc=%0d got=%h want=03", i, ir_pc); end
    end
    stall = 1'b0;
    branch_valid = 1'b1;
    branch_target = 8'h00;
    tick();
    branch_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL resume_halted got=%b want=0", halted); end
    checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL resume_address got=%h want=00", address); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL resume_ir_valid got=%b want=0", ir_valid); end
    pushExp(8'h00);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL resume_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL resume_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL resume_fetch_valid got=%b want=1", ir_valid); end
  endtask

  task automatic test_branch_under_stall();
    exp_t e;
    stall = 1'b1;
    branch_valid = 1'b1;
    branch_target = 8'h40;
    tick();
    stall = 1'b0;
    branch_valid = 1'b0;
    checks++; if (address !== 8'h40) begin failures++; $display("[TB] FAIL bstall_address got=%h want=40", address); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL bstall_flush got=%b want=0", ir_valid); end
    checks++; if (ir !== 9'h141) begin failures++; $display("[TB] FAIL bstall_ir_hold got=%h want=141", ir); end
    checks++; if (ir_pc !== 8'h00) begin failures++; $display("[TB] FAIL bstall_ir_pc_hold got=%h want=00", ir_pc); end
    pushExp(8'h40);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL btarget_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL btarget_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL btarget_ir_valid got=%b want=1", ir_valid); end
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [7:0] a;
    branch_valid = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_valid = 1'b0;
    checks++; if (address !== 8'hFE) begin failures++; $display("[TB] FAIL wrap_branch_address got=%h want=fe", address); end
    a = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      pushExp(a);
      tick();
      e = sbQ.pop_front();
      checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL wrap_ir_pc k=%0d got=%h want=%h", k, ir_pc, e.pc); end
      checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL wrap_ir k=%0d got=%h want=%h", k, ir, e.instr); end
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_ir_valid k=%0d got=%b want=1", k, ir_valid); end
      a = a + 8'h01;
    end
  endtask

  task automatic test_halt_under_stall();
    exp_t e;
    pushExp(8'h02);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL hs_pre_ir got=%h want=%h", ir, e.instr); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL hs_halted got=%b want=0", halted); end
      checks++; if (ir !== 9'h0D4) begin failures++; $display("[TB] FAIL hs_ir got=%h want=0d4", ir); end
      checks++; if (address !== 8'h03) begin failures++; $display("[TB] FAIL hs_address got=%h want=03", address); end
    end
    stall = 1'b0;
    pushExp(8'h03);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL hs_halt_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL hs_halt_valid got=%b want=1", ir_valid); end
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL hs_halted_after got=%b want=1", halted); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL hs_valid_after got=%b want=0", ir_valid); end
  endtask

  task automatic test_reset_in_halted();
    exp_t e;
    reset = 1'b1;
    branch_valid = 1'b1;
    branch_target = 8'h55;
    stall = 1'b1;
    tick();
    checks++; if (address !== 8'h00) begin failures++; $display("[TB] FAIL rh_address got=%h want=00", address); end
    checks++; if (ir !== 9'h000) begin failures++; $display("[TB] FAIL rh_ir got=%h want=000", ir); end
    checks++; if (ir_pc !== 8'h00) begin failures++; $display("[TB] FAIL rh_ir_pc got=%h want=00", ir_pc); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL rh_ir_valid got=%b want=0", ir_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL rh_halted got=%b want=0", halted); end
    reset = 1'b0;
    branch_valid = 1'b0;
    stall = 1'b0;
    tick();
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL rh_idle_valid got=%b want=0", ir_valid); end
    pushExp(8'h00);
    tick();
    e = sbQ.pop_front();
    checks++; if (ir_pc !== e.pc) begin failures++; $display("[TB] FAIL rh_first_ir_pc got=%h want=%h", ir_pc, e.pc); end
    checks++; if (ir !== e.instr) begin failures++; $display("[TB] FAIL rh_first_ir got=%h want=%h", ir, e.instr); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL rh_first_valid got=%b want=1", ir_valid); end
  endtask

  // Guard against a hang; normal runs finish long before this.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {1'b0, 8'(i)};
    rom[0] = 9'h141;
    rom[1] = 9'h0D1;
    rom[2] = 9'h0D4;
    rom[3] = 9'h1E0;
    reset = 1'b1;
    stall = 1'b0;
    branch_valid = 1'b0;
    branch_target = 8'h00;

    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_branch_under_stall();
    test_wrap();
    test_halt_under_stall();
    test_reset_in_halted();

    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 8, program-counter and ROM address width.
REQ-002 SHALL have parameter INSTR_WIDTH, 9, instruction word width.
REQ-003 SHALL have parameter RESET_PC, 0, PC value loaded on reset.
REQ-004 SHALL have parameter HALT_OPCODE, 4'b1111, opcode (instruction[8:5]) that stops fetch.
REQ-005 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port address  output  ADDR_WIDTH  ROM address, equal to current PC register.
REQ-008 SHALL have port instruction  input  INSTR_WIDTH  ROM data, combinational from address, valid same cycle.
REQ-009 SHALL have port stall  input  1  downstream not ready; hold IR and PC.
REQ-010 SHALL have port branch_valid  input  1  redirect fetch this cycle.
REQ-011 SHALL have port branch_target  input  ADDR_WIDTH  redirect address.
REQ-012 SHALL have port ir  output  INSTR_WIDTH  latched instruction register.
REQ-013 SHALL have port ir_pc  output  ADDR_WIDTH  address from which ir was fetched.
REQ-014 SHALL have port ir_valid  output  1  ir holds a live instruction.
REQ-015 SHALL have port opcode  output  4  ir[8:5], combinational from ir.
REQ-016 SHALL have port halted  output  1  high while in HALTED state.

Function
REQ-017 SHALL implement states IDLE, RUN, HALTED; reset enters IDLE.
REQ-018 IDLE SHALL last exactly one cycle, ir_valid=0, PC unchanged, then go to RUN (a branch_valid in IDLE loads PC=branch_target and still goes to RUN).
REQ-019 In RUN with stall=0, branch_valid=0: ir<=instruction, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
REQ-020 Fetch latency SHALL be one cycle: instruction at address A appears on ir the cycle after address=A.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_WIDTH (255 -> 0 at default width), no flag, no stop.
REQ-022 In RUN with stall=1, branch_valid=0: PC, ir, ir_pc, ir_valid SHALL all hold.
REQ-023 branch_valid=1 in RUN SHALL take priority over stall: PC<=branch_target, ir_valid<=0 (flush), ir/ir_pc hold old value.
REQ-024 Instruction at branch_target SHALL appear on ir with ir_valid=1 two cycles after the branch_valid cycle, absent stall.
REQ-025 In RUN, when a latched fetch has instruction[8:5]==HALT_OPCODE: ir gets the halt word, ir_valid<=1, PC NOT incremented, state -> HALTED.
REQ-026 HALTED SHALL set halted=1, hold PC and ir_pc, drop ir_valid to 0 on the first HALTED cycle and keep it 0; stall ignored.
REQ-027 branch_valid=1 in HALTED SHALL load PC=branch_target, go to RUN, halted=0 next cycle.
REQ-028 A halt word fetched while stall=1 SHALL NOT be latched nor cause HALTED (stall freezes fetch).
REQ-029 Priority, highest first: reset > branch_valid > stall > halt detection > normal fetch.
REQ-030 Unknown or undefined opcodes SHALL be fetched as normal instructions; no decode beyond halt detection and opcode field.

Reset
REQ-031 On reset: PC=RESET_PC, address=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, state=IDLE.
REQ-032 Reset asserted mid-stall, mid-branch or in HALTED SHALL override all inputs in that cycle.
REQ-033 First ir_valid=1 after reset release SHALL occur on cycle 2 (IDLE cycle 1, fetch of RESET_PC latched end of cycle 2).

Verification
REQ-034 Sequential run: ROM 0:0x141,1:0x0D1,2:0x0D4, no stall -> ir = 0x141,0x0D1,0x0D4 on consecutive cycles, ir_pc=0,1,2, ir_valid=1.
REQ-035 Stall: assert stall 3 cycles while ir=0x0D1 -> ir, ir_pc=1, address=2 held 3 cycles, then 0x0D4 latched.
REQ-036 Branch under stall: stall=1, branch_valid=1, target=0x40 -> next cycle address=0x40, ir_valid=0; two cycles after the branch, ir=ROM[0x40], ir_pc=0x40, ir_valid=1.
REQ-037 Wrap: branch to 0xFE, ROM[0xFE..0x01] non-halt -> ir_pc sequence 0xFE,0xFF,0x00,0x01.
REQ-038 Halt: ROM[3]=0x1E0 -> ir=0x1E0, ir_valid=1 one cycle, then halted=1, ir_valid=0, address=3 held 10 cycles; branch_valid target=0 -> halted=0, run resumes from 0.
REQ-039 Reset in HALTED: reset one cycle -> all outputs per REQ-031 next cycle, first ir_valid=1 with ir_pc=0 per REQ-033.
